// File: rtl/ja_block_responder_if.sv
// Bundle of the local block-load handshake and the JA byte-link signals
// for the block responder. The responder uses the slave modport. Local
// logic and the peer-facing pin model use the master modport.
interface ja_block_responder_if #(
    parameter int NBYTES = 16
);
    logic [8*NBYTES-1:0] blk_in;
    logic                load_valid;
    logic                load_ready;
    logic [7:0]          ja_in;
    logic [7:0]          ja_out;
    logic                ja_oe;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output blk_in, load_valid, ja_in,
        input  load_ready, ja_out, ja_oe, busy, done, err
    );

    modport slave (
        input  blk_in, load_valid, ja_in,
        output load_ready, ja_out, ja_oe, busy, done, err
    );
endinterface

// File: rtl/ja_block_responder.sv
// Responder end of the 8-bit JA byte link. A block is loaded from local
// logic. Each rising 0xFF request from the peer is answered by driving the
// next block byte (MSB byte first) for exactly one cycle. The tristate
// buffer lives at the top level. This block only produces ja_out/ja_oe.
module ja_block_responder #(
    parameter int          NBYTES   = 16,
    parameter logic [7:0]  REQ_CODE = 8'hFF,
    parameter int          TIMEOUT  = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ja_block_responder_if.slave   bus
);
    localparam int BLK_W = 8 * NBYTES;
    localparam int CNT_W = $clog2(NBYTES + 1);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DRIVE,
        ST_TURN
    } state_t;

    state_t             state_q;
    logic [BLK_W-1:0]   shift_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [7:0]         s1_q;
    logic [7:0]         s2_q;
    logic [7:0]         s3_q;
    logic               req_q;
    logic               req_d;
    logic [7:0]         ja_out_q;
    logic               ja_oe_q;
    logic               load_ready_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    // Rising match on the synchronized pins. Ignored during turnaround, so
    // our own byte or an echo of it cannot look like a fresh request.
    assign req_d = (s2_q == REQ_CODE) && (s3_q != REQ_CODE) && (state_q != ST_TURN);

    // Two-flop synchronizer plus history flop, and the registered request strobe.
    // During TURN the history is forced to REQ_CODE to block a retrigger.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q  <= 8'h00;
            s2_q  <= 8'h00;
            s3_q  <= 8'h00;
            req_q <= 1'b0;
        end else begin
            s1_q  <= bus.ja_in;
            s2_q  <= s1_q;
            s3_q  <= (state_q == ST_TURN) ? REQ_CODE : s2_q;
            req_q <= req_d;
        end
    end

    // Transfer FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            to_cnt_q     <= '0;
            ja_out_q     <= 8'h00;
            ja_oe_q      <= 1'b0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.load_valid) begin
                        shift_q      <= bus.blk_in;
                        byte_cnt_q   <= '0;
                        to_cnt_q     <= '0;
                        load_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (req_q) begin
                        ja_out_q   <= shift_q[BLK_W-1 -: 8];
                        ja_oe_q    <= 1'b1;
                        shift_q    <= shift_q << 8;
                        byte_cnt_q <= byte_cnt_q + CNT_W'(1);
                        state_q    <= ST_DRIVE;
                    end else if (byte_cnt_q != '0) begin
                        // The wait for the first byte is unbounded. Only
                        // a stalled transfer already under way is aborted.
                        if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                            err_q        <= 1'b1;
                            load_ready_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                end
                ST_DRIVE: begin
                    ja_oe_q <= 1'b0;
                    state_q <= ST_TURN;
                end
                ST_TURN: begin
                    if (byte_cnt_q == CNT_W'(NBYTES)) begin
                        done_q       <= 1'b1;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        to_cnt_q <= '0;
                        state_q  <= ST_ARMED;
                    end
                end
                default: begin
                    ja_oe_q      <= 1'b0;
                    load_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ja_out     = ja_out_q;
    assign bus.ja_oe      = ja_oe_q;
    assign bus.load_ready = load_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_ja_block_responder.sv
// Testbench for ja_block_responder. The stimulus side plays local logic
// and the peer initiator. For every request it expects to be serviced, it
// pushes the next block byte (and a done marker after the last byte) onto
// an expectation queue. A negedge monitor pops one entry per observed byte,
// done or err.
module tb_ja_block_responder;
    localparam int NB  = 16;
    localparam int TO  = 1024;
    localparam int BW  = 8 * NB;

    typedef enum int { EV_BYTE, EV_DONE, EV_ERR } ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ja_block_responder_if #(.NBYTES(NB)) bus ();

    ja_block_responder #(
        .NBYTES  (NB),
        .REQ_CODE(8'hFF),
        .TIMEOUT (TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    ev_t        exp_q[$];
    logic [7:0] model_bytes[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, req);
        end
    endtask

    task automatic score(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got %s %02h required nothing", k.name(), d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_BYTE && e.data != d)) begin
                errors++;
                $display("FAIL scoreboard got %s %02h required %s %02h",
                         k.name(), d, e.kind.name(), e.data);
            end else begin
                $display("ok %s %02h at %0t", k.name(), d, $time);
            end
        end
    endtask

    // Monitor: every visible output event must match the next expectation.
    always @(negedge clk) begin
        if (bus.ja_oe === 1'b1) score(EV_BYTE, bus.ja_out);
        if (bus.done === 1'b1)  score(EV_DONE, 8'h00);
        if (bus.err === 1'b1)   score(EV_ERR, 8'h00);
    end

    function automatic logic [BW-1:0] rand_blk();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Model: the block becomes a queue of bytes, MSB byte first.
    task automatic load_block(input logic [BW-1:0] b);
        @(negedge clk);
        chk("load_ready_before_load", bus.load_ready, 1);
        bus.blk_in     = b;
        bus.load_valid = 1'b1;
        model_bytes.delete();
        for (int i = 0; i < NB; i++) model_bytes.push_back(b[BW-1-8*i -: 8]);
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.blk_in     = rand_blk();
        chk("busy_after_load", bus.busy, 1);
        chk("load_ready_after_load", bus.load_ready, 0);
    endtask

    task automatic push_next_byte();
        ev_t e;
        e.kind = EV_BYTE;
        e.data = model_bytes.pop_front();
        exp_q.push_back(e);
        if (model_bytes.size() == 0) begin
            e.kind = EV_DONE;
            e.data = 8'h00;
            exp_q.push_back(e);
        end
    endtask

    // Peer request: 0xFF for h cycles, then 0x00 for gap cycles.
    task automatic request(input int h, input int gap, input bit serviced);
        if (serviced && model_bytes.size() != 0) push_next_byte();
        bus.ja_in = 8'hFF;
        repeat (h) @(negedge clk);
        bus.ja_in = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    task automatic rand_requests(input int n);
        for (int i = 0; i < n; i++) request($urandom_range(1, 3), $urandom_range(4, 6), 1'b1);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d pending required 0 pending", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout required finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t  e;
        logic seen;

        rst            = 1'b1;
        bus.ja_in      = 8'h00;
        bus.load_valid = 1'b0;
        bus.blk_in     = '0;
        repeat (2) @(negedge clk);
        chk("rst_ja_oe", bus.ja_oe, 0);
        chk("rst_load_ready", bus.load_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;

        // Directed block. First request also probes the exact drive cycle.
        load_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
        push_next_byte();
        bus.ja_in = 8'hFF;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            #1;
            if (i == 1) bus.ja_in = 8'h00;
            chk($sformatf("latency_oe_c%0d", i), bus.ja_oe, (i == 4) ? 1 : 0);
        end
        for (int i = 1; i < NB; i++) request(1, 4, 1'b1);
        drain(50, "directed_block_drain");
        chk("directed_load_ready_after_done", bus.load_ready, 1);
        chk("directed_busy_after_done", bus.busy, 0);

        // Held request counts once; a fresh rising match gets the next byte.
        load_block(rand_blk());
        request(10, 4, 1'b1);
        drain(20, "held_request_one_byte");
        request(1, 4, 1'b1);
        drain(20, "second_byte_after_release");
        rand_requests(NB - 2);
        drain(50, "held_block_drain");

        // Random blocks with random request shapes.
        for (int b = 0; b < 3; b++) begin
            load_block(rand_blk());
            rand_requests(NB);
            drain(50, "random_block_drain");
        end

        // Timeout after 3 bytes.
        load_block(rand_blk());
        rand_requests(3);
        drain(30, "timeout_prefix_drain");
        model_bytes.delete();
        e.kind = EV_ERR;
        e.data = 8'h00;
        exp_q.push_back(e);
        repeat (TO - 40) @(negedge clk);
        #1;
        chk("timeout_not_early", exp_q.size(), 1);
        chk("timeout_busy_before", bus.busy, 1);
        drain(100, "timeout_err_drain");
        chk("timeout_busy_after", bus.busy, 0);
        chk("timeout_ja_oe_after", bus.ja_oe, 0);
        chk("timeout_load_ready_after", bus.load_ready, 1);
        load_block(rand_blk());
        rand_requests(NB);
        drain(50, "after_timeout_block_drain");

        // Unbounded wait for the first request; loads while busy are ignored.
        load_block(rand_blk());
        repeat (100) @(negedge clk);
        bus.blk_in     = rand_blk();
        bus.load_valid = 1'b1;
        @(negedge clk);
        bus.load_valid = 1'b0;
        repeat (4900) @(negedge clk);
        #1;
        chk("long_wait_busy", bus.busy, 1);
        chk("long_wait_no_err", bus.err, 0);
        rand_requests(NB);
        drain(50, "long_wait_block_drain");

        // Reset while byte 5 is driven.
        load_block(rand_blk());
        rand_requests(5);
        drain(30, "reset_prefix_drain");
        push_next_byte();
        bus.ja_in = 8'hFF;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (n == 0) bus.ja_in = 8'h00;
            if (bus.ja_oe === 1'b1) seen = 1'b1;
        end
        chk("byte5_drive_seen", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_mid_ja_oe", bus.ja_oe, 0);
        chk("reset_mid_busy", bus.busy, 0);
        chk("reset_mid_load_ready", bus.load_ready, 1);
        rst = 1'b0;
        model_bytes.delete();
        repeat (3) @(negedge clk);
        request(1, 4, 1'b0);
        request(3, 8, 1'b0);
        #1;
        chk("after_reset_idle_busy", bus.busy, 0);
        chk("after_reset_no_pending", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ja_block_responder.md
Name: ja_block_responder

Overview:
- Responder end of the 8-bit JA board-to-board byte link.
- Accepts one 128-bit block (typically the aes_256 ciphertext) from local logic. Then answers each 0xFF request strobe from the peer initiator by driving the next block byte onto JA for exactly one cycle, MSB byte first.
- Top level owns the tristate: JA = ja_oe ? ja_out : 8'bz. This block sees ja_in = JA.

Parameters:
- NBYTES, 16, bytes per block; block width is 8*NBYTES.
- REQ_CODE, 8'hFF, byte value the peer drives to request the next byte.
- TIMEOUT, 1024, idle cycles allowed in ARMED after the first byte is sent before the transfer aborts.

Ports:
- CLK  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- blk_in  in  8*NBYTES  block to send; byte 0 is blk_in[8*NBYTES-1 -: 8].
- load_valid  in  1  blk_in valid.
- load_ready  out  1  block can be accepted; high only in IDLE.
- ja_in  in  8  raw JA pins, asynchronous to CLK.
- ja_out  out  8  byte driven to JA.
- ja_oe  out  1  JA output enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last byte's turnaround.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Everything is synchronous to posedge CLK. Reset has priority over all other inputs.
- Reset values:
  - state IDLE, byte counter 0, timeout counter 0, shift register 0, synchronizer flops 0.
  - ja_out=0, ja_oe=0, load_ready=1, busy=0, done=0, err=0.
- Reset mid-transfer (including during DRIVE) releases JA on the next edge and discards the block.
- Input path:
  - Two-flop synchronizer s1 <- ja_in, s2 <- s1, plus a history flop s3 <- s2.
  - A request is s2==REQ_CODE && s3!=REQ_CODE (rising match). A peer holding 0xFF for several cycles counts as one request.
- States:
  - IDLE: load_ready=1. On load_valid, capture blk_in into the shift register, clear both counters, go to ARMED. A request seen in IDLE is ignored.
  - ARMED: waiting for a request.
    - On a request: ja_out <= shift[MSB byte], ja_oe <= 1, shift <<= 8, byte counter +1, go to DRIVE.
    - Timeout counter increments every ARMED cycle with no request, but only once byte counter > 0. The wait for the first request is unbounded.
    - If the timeout counter reaches TIMEOUT-1 with no request, pulse err and go to IDLE.
  - DRIVE: exactly one cycle with ja_oe=1. Then ja_oe <= 0 and go to TURN.
  - TURN: one bus-turnaround cycle. Request detection is suppressed here, and s3 is forced to REQ_CODE so our own or echoed 0xFF cannot retrigger.
    - If byte counter == NBYTES: pulse done and go to IDLE.
    - Otherwise clear the timeout counter and go to ARMED.
- Latency: if ja_in first equals REQ_CODE at capture edge k, the request is detected at edge k+2, and ja_oe=1 with valid ja_out holds for the cycle between edges k+3 and k+4.
- ja_out holds its last value when ja_oe=0. Verify only when ja_oe=1.
- Minimum spacing between serviced requests is 3 cycles (ARMED, DRIVE, TURN). A request arriving during DRIVE or TURN is dropped. The peer must re-issue it as a fresh rising match.
- load_valid outside IDLE is ignored, and blk_in is not re-sampled.
- done and err are never asserted in the same cycle.
- Byte counter width is clog2(NBYTES+1). It does not wrap, because IDLE is entered at NBYTES.

Test Plan:
- Reset=1 for 2 cycles, then 0 → ja_oe=0, load_ready=1, busy=0, done=0, err=0.
- Load blk_in=128'h00112233_44556677_8899AABB_CCDDEEFF. Issue 16 requests, each 0xFF held 1 cycle then 0x00 for 4 cycles → ja_out sequence 00,11,…,FF, each with a single ja_oe cycle. done pulses once, then load_ready=1.
- Peer holds 0xFF for 10 cycles → exactly one byte is driven (0x00). A second byte appears only after ja_in leaves and re-enters 0xFF.
- Send 3 bytes, then no request for TIMEOUT cycles → err pulses once, state IDLE, ja_oe=0. A new load restarts at byte 0.
- Loaded but no request for 5000 cycles → no err, busy=1. The first request then drives byte 0.
- Assert Reset during DRIVE of byte 5 → ja_oe=0 on the next edge, and a later 0xFF request drives nothing until a new load.
